// File: rtl/tick_scheduler.sv
// Multi-channel timebase: a shared prescaler produces base ticks, and per-channel
// counters divide them into tick strobes and square waves; periods load via req/ack.
module tick_scheduler #(
    parameter int PRESCALE = 50000,
    parameter int NCH      = 4,
    parameter int CW       = 16,
    parameter int CHW      = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [NCH-1:0] ch_en,
    input  logic           cfg_req,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_period,
    output logic           cfg_ack,
    output logic           base_tick,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_ACK
    } cfg_state_e;

    cfg_state_e     state_q, state_d;
    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic           base_tick_q, base_tick_d;
    logic           cfg_ack_q, cfg_ack_d;
    logic [CHW-1:0] cfg_ch_q, cfg_ch_d;
    logic [CW-1:0]  cfg_period_q, cfg_period_d;
    logic [CW-1:0]  period_q [NCH];
    logic [CW-1:0]  period_d [NCH];
    logic [CW-1:0]  ccnt_q [NCH];
    logic [CW-1:0]  ccnt_d [NCH];
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] sq_q, sq_d;

    logic           pwrap;
    logic           apply;
    logic [NCH-1:0] write_hit;

    // Prescaler and configuration handshake.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pwrap        = en && (pcnt_q == PMAX);
        pcnt_d       = pcnt_q;
        if (en) begin
            pcnt_d = pwrap ? '0 : pcnt_q + 1'b1;
        end
        base_tick_d  = pwrap;

        state_d      = state_q;
        cfg_ch_d     = cfg_ch_q;
        cfg_period_d = cfg_period_q;
        cfg_ack_d    = 1'b0;
        apply        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_req) begin
                    state_d      = S_APPLY;
                    cfg_ch_d     = cfg_ch;
                    cfg_period_d = cfg_period;
                end
            end
            S_APPLY: begin
                state_d   = S_ACK;
                apply     = 1'b1;
                cfg_ack_d = 1'b1;
            end
            S_ACK: begin
                if (cfg_req) begin
                    cfg_ack_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Channel counters; a config write to a channel overrides its pwrap on the same edge.
    always_comb begin
        write_hit = '0;
        tick_d    = '0;
        sq_d      = sq_q;
        for (int i = 0; i < NCH; i++) begin
            write_hit[i] = apply && (cfg_ch_q == CHW'(i));
            period_d[i]  = write_hit[i] ? cfg_period_q : period_q[i];
            ccnt_d[i]    = ccnt_q[i];
            if (!ch_en[i]) begin
                ccnt_d[i] = '0;
                sq_d[i]   = 1'b0;
            end else if (write_hit[i] || (period_q[i] == '0)) begin
                ccnt_d[i] = '0;
            end else if (pwrap) begin
                if (ccnt_q[i] == period_q[i] - 1'b1) begin
                    ccnt_d[i] = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                end else begin
                    ccnt_d[i] = ccnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pcnt_q       <= '0;
            base_tick_q  <= 1'b0;
            cfg_ack_q    <= 1'b0;
            cfg_ch_q     <= '0;
            cfg_period_q <= '0;
            tick_q       <= '0;
            sq_q         <= '0;
            // NOTE: the period array is reset too, since every channel must restart at period 1.
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= CW'(1);
                ccnt_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            base_tick_q  <= base_tick_d;
            cfg_ack_q    <= cfg_ack_d;
            cfg_ch_q     <= cfg_ch_d;
            cfg_period_q <= cfg_period_d;
            tick_q       <= tick_d;
            sq_q         <= sq_d;
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= period_d[i];
                ccnt_q[i]   <= ccnt_d[i];
            end
        end
    end

    assign cfg_ack   = cfg_ack_q;
    assign base_tick = base_tick_q;
    assign tick      = tick_q;
    assign sq        = sq_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler (PRESCALE=4, CW=8, NCH=4): a vector table for the
// basic timebase and handshake, then hand sequences for the multi-cycle corner cases.
module tb_tick_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [NCH-1:0] ch_en;
    logic           cfg_req;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_period;
    logic           cfg_ack;
    logic           base_tick;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;

    tick_scheduler #(
        .PRESCALE (4),
        .NCH      (NCH),
        .CW       (CW),
        .CHW      (CHW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ch_en      (ch_en),
        .cfg_req    (cfg_req),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_ack    (cfg_ack),
        .base_tick  (base_tick),
        .tick       (tick),
        .sq         (sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           en;
        logic [NCH-1:0] ch_en;
        logic           req;
        logic [CHW-1:0] ch;
        logic [CW-1:0]  period;
        int             n;      // edges to advance before comparing
        logic           bt;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] sq;
        logic           ack;
    } vec_t;

    vec_t vecs [13];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    function automatic vec_t mkv(input logic e, input logic [NCH-1:0] ce, input logic r,
                                 input logic [CHW-1:0] c, input logic [CW-1:0] p, input int n,
                                 input logic bt, input logic [NCH-1:0] tk,
                                 input logic [NCH-1:0] s, input logic a);
        vec_t v;
        v.en = e; v.ch_en = ce; v.req = r; v.ch = c; v.period = p; v.n = n;
        v.bt = bt; v.tk = tk; v.sq = s; v.ack = a;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_outs(input string name, input logic bt, input logic [NCH-1:0] tk,
                              input logic [NCH-1:0] s, input logic ack);
        check({name, ".base_tick"}, 32'(base_tick), 32'(bt));
        check({name, ".tick"},      32'(tick),      32'(tk));
        check({name, ".sq"},        32'(sq),        32'(s));
        check({name, ".cfg_ack"},   32'(cfg_ack),   32'(ack));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic cfg_start(input logic [CHW-1:0] c, input logic [CW-1:0] p);
        cfg_ch     = c;
        cfg_period = p;
        cfg_req    = 1'b1;
        step(1);
        check("hs.ack_after_1_edge", 32'(cfg_ack), 32'd0);
        step(1);
        check("hs.ack_after_2_edges", 32'(cfg_ack), 32'd1);
    endtask

    task automatic cfg_finish();
        cfg_req = 1'b0;
        step(1);
        check("hs.ack_drop", 32'(cfg_ack), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int bad;

        // Default period, then ch2 reconfigured to period 3.
        vecs[0]  = mkv(1, 4'b0001, 0, 0, 0, 3,  0, 4'b0000, 4'b0000, 0);
        vecs[1]  = mkv(1, 4'b0001, 0, 0, 0, 1,  1, 4'b0001, 4'b0001, 0);
        vecs[2]  = mkv(1, 4'b0001, 0, 0, 0, 1,  0, 4'b0000, 4'b0001, 0);
        vecs[3]  = mkv(1, 4'b0001, 0, 0, 0, 3,  1, 4'b0001, 4'b0000, 0);
        vecs[4]  = mkv(1, 4'b0001, 0, 0, 0, 4,  1, 4'b0001, 4'b0001, 0);
        vecs[5]  = mkv(1, 4'b0100, 1, 2, 3, 1,  0, 4'b0000, 4'b0000, 0);
        vecs[6]  = mkv(1, 4'b0100, 1, 2, 3, 1,  0, 4'b0000, 4'b0000, 1);
        vecs[7]  = mkv(1, 4'b0100, 1, 2, 3, 1,  0, 4'b0000, 4'b0000, 1);
        vecs[8]  = mkv(1, 4'b0100, 0, 2, 3, 1,  1, 4'b0000, 4'b0000, 0);
        vecs[9]  = mkv(1, 4'b0100, 0, 2, 3, 4,  1, 4'b0000, 4'b0000, 0);
        vecs[10] = mkv(1, 4'b0100, 0, 2, 3, 4,  1, 4'b0100, 4'b0100, 0);
        vecs[11] = mkv(1, 4'b0100, 0, 2, 3, 1,  0, 4'b0000, 4'b0100, 0);
        vecs[12] = mkv(1, 4'b0100, 0, 2, 3, 11, 1, 4'b0100, 4'b0000, 0);

        rst = 1'b0; en = 1'b0; ch_en = '0; cfg_req = 1'b0; cfg_ch = '0; cfg_period = '0;
        #12;
        check_outs("reset", 0, 4'b0000, 4'b0000, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;

        foreach (vecs[k]) begin
            en = vecs[k].en; ch_en = vecs[k].ch_en; cfg_req = vecs[k].req;
            cfg_ch = vecs[k].ch; cfg_period = vecs[k].period;
            step(vecs[k].n);
            check_outs($sformatf("vec%0d", k), vecs[k].bt, vecs[k].tk, vecs[k].sq, vecs[k].ack);
        end

        // Period 0 on ch1: let it toggle sq once, then freeze it.
        ch_en = 4'b0110;
        run_to(40);
        check("p0.pre_tick1", 32'(tick[1]), 32'd1);
        check("p0.pre_sq1", 32'(sq[1]), 32'd1);
        cfg_start(2'd1, 8'd0);
        cfg_finish();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (tick[1] !== 1'b0 || sq[1] !== 1'b1) bad++;
        end
        check("p0.frozen_bad_cycles", 32'(bad), 32'd0);

        // Write/pwrap collision on ch0 at edge 156, where ch2 also expires.
        ch_en = 4'b0111;
        run_to(154);
        check("coll.pre_sq", 32'(sq), 32'b0111);
        cfg_start(2'd0, 8'd2);
        check_outs("coll.apply_edge", 1, 4'b0100, 4'b0011, 1);
        cfg_finish();
        run_to(160);
        check_outs("coll.pwrap1", 1, 4'b0000, 4'b0011, 0);
        run_to(164);
        check_outs("coll.pwrap2", 1, 4'b0001, 4'b0010, 0);

        // en pause with pcnt=2.
        run_to(166);
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (base_tick !== 1'b0 || tick !== 4'b0000) bad++;
        end
        check("pause.bad_cycles", 32'(bad), 32'd0);
        check("pause.sq_held", 32'(sq), 32'b0010);
        en = 1'b1;
        step(1);
        check("pause.bt_resume1", 32'(base_tick), 32'd0);
        step(1);
        check_outs("pause.resume2", 1, 4'b0100, 4'b0110, 0);

        // Reset while the FSM sits in ACK.
        step(2);
        cfg_start(2'd3, 8'd5);
        check_outs("rst.pre", 1, 4'b0001, 4'b0111, 1);
        #2;
        rst = 1'b0;
        #1;
        check_outs("rst.async", 0, 4'b0000, 4'b0000, 0);
        cfg_req = 1'b0;
        ch_en = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        step(3);
        check_outs("rst.after3", 0, 4'b0000, 4'b0000, 0);
        step(1);
        check_outs("rst.first_bt", 1, 4'b1111, 4'b1111, 0);
        cfg_start(2'd3, 8'd2);
        cfg_finish();
        step(1);
        check_outs("rst.new_cfg_pwrap1", 1, 4'b0111, 4'b1000, 0);
        step(4);
        check_outs("rst.new_cfg_pwrap2", 1, 4'b1111, 4'b0111, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
